obd_line_parser: RTL and testbench



---
 rtl/blastit_parser_pkg.sv | 16 +
 rtl/hex_nibble_decode.sv | 24 ++
 rtl/obd_line_parser.sv | 159 +++++++++++++++
 tb/tb_obd_line_parser.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/blastit_parser_pkg.sv
// Shared constants for the OBD line parser: ASCII control characters and FSM states.
package blastit_parser_pkg;

  localparam logic [7:0] CHR_CR     = 8'h0D;
  localparam logic [7:0] CHR_LF     = 8'h0A;
  localparam logic [7:0] CHR_SP     = 8'h20;
  localparam logic [7:0] CHR_PROMPT = 8'h3E;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_POP   = 2'd1,
    S_PROC  = 2'd2,
    S_READY = 2'd3
  } state_t;

endpackage

// File: rtl/hex_nibble_decode.sv
// ASCII hex digit decoder: maps '0'-'9', 'A'-'F', 'a'-'f' to a 4-bit value.
module hex_nibble_decode (
  input  logic [7:0] ch,
  output logic [3:0] value,
  output logic       is_hex
);

  // Range-based decode; value is 0 for non-hex characters.
  always_comb begin
    value  = 4'h0;
    is_hex = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      value  = 4'(ch - 8'h30);
      is_hex = 1'b1;
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      value  = 4'(ch - 8'h37);
      is_hex = 1'b1;
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      value  = 4'(ch - 8'h57);
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/obd_line_parser.sv
// OBD (ELM327-style) response line parser sitting behind the uart RX FIFO.
// Pops characters, decodes space-separated hex pairs into a byte buffer and
// holds each completed line for the MCU until it pulses clear.
// Optional macro OBD_PARSER_CHECKSUM_EN builds a mod-256 sum of stored bytes.
//
// state   | meaning
// S_WAIT  | idle, waiting for a character in the FIFO
// S_POP   | pop strobe to FIFO, capture head character
// S_PROC  | decode the captured character
// S_READY | line complete and frozen, waiting for clear
module obd_line_parser
  import blastit_parser_pkg::*;
#(
  parameter int MAX_BYTES = 16,
  parameter int IDX_BITS  = 4,
  parameter int CNT_BITS  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_empty,
  input  logic [7:0]          r_data,
  output logic                rd_uart,
  input  logic                clear,
  input  logic [IDX_BITS-1:0] byte_idx,
  output logic [7:0]          byte_out,
  output logic [CNT_BITS-1:0] byte_count,
  output logic                line_ready,
  output logic                prompt_tick,
  output logic                e_char,
  output logic                e_nibble,
  output logic                e_ovf,
  output logic [7:0]          checksum
);

  state_t        state, state_nxt;
  logic [7:0]    ch_reg;
  logic          have_hi;
  logic [3:0]    hi_nib;
  logic [7:0]    buffer [MAX_BYTES];
  logic [3:0]    nib_val;
  logic          nib_is_hex;
  logic          in_proc;
  logic          buf_full;
  logic          pair_done;
  logic          store_byte;
  logic          line_clr;
  logic          cr_terminates;
  logic [7:0]    new_byte;

  hex_nibble_decode u_hex (
    .ch     (ch_reg),
    .value  (nib_val),
    .is_hex (nib_is_hex)
  );

  assign in_proc    = (state == S_PROC);
  assign buf_full   = (byte_count == CNT_BITS'(MAX_BYTES));
  assign pair_done  = in_proc && nib_is_hex && have_hi;
  assign store_byte = pair_done && !buf_full;
  assign new_byte   = {hi_nib, nib_val};
  assign line_clr   = (in_proc && ch_reg == CHR_PROMPT) || (state == S_READY && clear);
  // A lone high nibble at CR raises e_nibble, so it also makes the line non-blank.
  assign cr_terminates = have_hi || (byte_count != '0) || e_char || e_nibble || e_ovf;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= state_nxt;
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_nxt  = state;
    rd_uart    = 1'b0;
    line_ready = 1'b0;
    case (state)
      S_WAIT:  if (!rx_empty) state_nxt = S_POP;
      S_POP: begin
        rd_uart   = 1'b1;
        state_nxt = S_PROC;
      end
      S_PROC: begin
        if (ch_reg == CHR_CR && cr_terminates) state_nxt = S_READY;
        else                                   state_nxt = S_WAIT;
      end
      S_READY: begin
        line_ready = 1'b1;
        if (clear) state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Per-line control state: character capture, nibble pairing, count and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_reg      <= 8'h00;
      have_hi     <= 1'b0;
      hi_nib      <= 4'h0;
      byte_count  <= '0;
      prompt_tick <= 1'b0;
      e_char      <= 1'b0;
      e_nibble    <= 1'b0;
      e_ovf       <= 1'b0;
    end else begin
      prompt_tick <= 1'b0;
      if (state == S_POP) ch_reg <= r_data;
      if (line_clr) begin
        have_hi     <= 1'b0;
        byte_count  <= '0;
        e_char      <= 1'b0;
        e_nibble    <= 1'b0;
        e_ovf       <= 1'b0;
        prompt_tick <= in_proc;
      end else if (in_proc) begin
        if (nib_is_hex) begin
          if (!have_hi) begin
            hi_nib  <= nib_val;
            have_hi <= 1'b1;
          end else begin
            have_hi <= 1'b0;
            if (buf_full) e_ovf      <= 1'b1;
            else          byte_count <= byte_count + CNT_BITS'(1);
          end
        end else if (ch_reg == CHR_SP || ch_reg == CHR_CR) begin
          if (have_hi) e_nibble <= 1'b1;
          have_hi <= 1'b0;
        end else if (ch_reg != CHR_LF) begin
          e_char <= 1'b1;
        end
      end
    end
  end

  // Byte buffer; contents only matter once counted, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_BYTES; i++)
      if (store_byte && byte_count == CNT_BITS'(i)) buffer[i] <= new_byte;
  end

  // Indexed read, forced to zero beyond the decoded byte count.
  always_comb begin
    byte_out = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++)
      if (byte_idx == IDX_BITS'(i) && CNT_BITS'(i) < byte_count) byte_out = buffer[i];
  end

`ifdef OBD_PARSER_CHECKSUM_EN
  // Running mod-256 sum of stored bytes; frozen with the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           checksum <= 8'h00;
    else if (line_clr)   checksum <= 8'h00;
    else if (store_byte) checksum <= checksum + new_byte;
  end
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_obd_line_parser.sv
// Directed testbench for obd_line_parser with a small behavioural RX FIFO.
module tb_obd_line_parser;

  localparam int IDX_BITS = 5;
  localparam int CNT_BITS = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                rx_empty;
  logic [7:0]          r_data;
  logic                rd_uart;
  logic                clear;
  logic [IDX_BITS-1:0] byte_idx;
  logic [7:0]          byte_out;
  logic [CNT_BITS-1:0] byte_count;
  logic                line_ready;
  logic                prompt_tick;
  logic                e_char;
  logic                e_nibble;
  logic                e_ovf;
  logic [7:0]          checksum;

  int tests = 0;
  int fails = 0;
  logic [7:0] fifo [$];
  logic pop_seen = 1'b0;
  int rd_count = 0;
  int prompt_count = 0;
  logic [7:0] exp_sum;

  obd_line_parser #(.MAX_BYTES(16), .IDX_BITS(IDX_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .r_data      (r_data),
    .rd_uart     (rd_uart),
    .clear       (clear),
    .byte_idx    (byte_idx),
    .byte_out    (byte_out),
    .byte_count  (byte_count),
    .line_ready  (line_ready),
    .prompt_tick (prompt_tick),
    .e_char      (e_char),
    .e_nibble    (e_nibble),
    .e_ovf       (e_ovf),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  task automatic fifo_refresh();
    rx_empty = (fifo.size() == 0);
    r_data   = (fifo.size() == 0) ? 8'h00 : fifo[0];
  endtask

  // Observe DUT strobes mid-cycle.
  always @(negedge clk) begin
    pop_seen = rd_uart;
    if (rd_uart) rd_count++;
    if (prompt_tick) prompt_count++;
  end

  // Pop the head shortly after the edge that consumed it.
  always @(posedge clk) begin
    #1;
    if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
    pop_seen = 1'b0;
    fifo_refresh();
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) fifo.push_back(s[i]);
    fifo_refresh();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!line_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'd0, line_ready}, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (fifo.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_drain"}, fifo.size(), 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_byte(input string tag, input int idx, input logic [7:0] exp);
    byte_idx = IDX_BITS'(idx);
    #1;
    chk(tag, {24'd0, byte_out}, {24'd0, exp});
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; byte_idx = '0;
    fifo_refresh();
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, line_ready}, 0);
    chk("rst_count", {27'd0, byte_count}, 0);
    chk("rst_rd", {31'd0, rd_uart}, 0);
    chk("rst_flags", {29'd0, e_char, e_nibble, e_ovf}, 0);
    chk("rst_prompt", {31'd0, prompt_tick}, 0);
    chk("rst_sum", {24'd0, checksum}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic line: 41+0C+1A+F8 = 0x15F -> 0x5F
    push_str("41 0C 1A F8\r");
    wait_ready("l1");
    chk("l1_count", {27'd0, byte_count}, 4);
    chk_byte("l1_b0", 0, 8'h41);
    chk_byte("l1_b1", 1, 8'h0C);
    chk_byte("l1_b2", 2, 8'h1A);
    chk_byte("l1_b3", 3, 8'hF8);
    chk_byte("l1_b4", 4, 8'h00);
    chk("l1_flags", {29'd0, e_char, e_nibble, e_ovf}, 0);
`ifdef OBD_PARSER_CHECKSUM_EN
    exp_sum = 8'h5F;
`else
    exp_sum = 8'h00;
`endif
    chk("l1_sum", {24'd0, checksum}, {24'd0, exp_sum});

    // Held line backpressures the FIFO.
    rd_count = 0;
    push_str("7E\r");
    repeat (20) @(negedge clk);
    chk("hold_rd", rd_count, 0);
    chk("hold_fifo", fifo.size(), 3);
    chk("hold_count", {27'd0, byte_count}, 4);
    pulse_clear();
    chk("clr_ready", {31'd0, line_ready}, 0);
    wait_ready("l2");
    chk("l2_count", {27'd0, byte_count}, 1);
    chk_byte("l2_b0", 0, 8'h7E);
`ifdef OBD_PARSER_CHECKSUM_EN
    exp_sum = 8'h7E;
`else
    exp_sum = 8'h00;
`endif
    chk("l2_sum", {24'd0, checksum}, {24'd0, exp_sum});
    pulse_clear();

    // Illegal char and lone nibbles.
    push_str("4G 1\r");
    wait_ready("l3");
    chk("l3_count", {27'd0, byte_count}, 0);
    chk("l3_echar", {31'd0, e_char}, 1);
    chk("l3_enib", {31'd0, e_nibble}, 1);
    chk("l3_eovf", {31'd0, e_ovf}, 0);
    pulse_clear();
    chk("l3_clr_flags", {29'd0, e_char, e_nibble, e_ovf}, 0);

    // Overflow: 17 bytes 0x00..0x10, only 16 kept; sum 0..15 = 0x78.
    push_str("00 01 02 03 04 05 06 07 08 09 0A 0B 0C 0D 0E 0F 10\r");
    wait_ready("l4");
    chk("l4_count", {27'd0, byte_count}, 16);
    chk("l4_eovf", {31'd0, e_ovf}, 1);
    chk("l4_enib", {31'd0, e_nibble}, 0);
    chk_byte("l4_b15", 15, 8'h0F);
    chk_byte("l4_b7", 7, 8'h07);
    chk_byte("l4_b16", 16, 8'h00);
`ifdef OBD_PARSER_CHECKSUM_EN
    exp_sum = 8'h78;
`else
    exp_sum = 8'h00;
`endif
    chk("l4_sum", {24'd0, checksum}, {24'd0, exp_sum});
    pulse_clear();

    // Blank line, LF, prompt.
    prompt_count = 0;
    push_str("\r\n>");
    wait_drain("l5");
    chk("l5_ready", {31'd0, line_ready}, 0);
    chk("l5_prompt", prompt_count, 1);
    chk("l5_count", {27'd0, byte_count}, 0);

    // Prompt discards a partial line.
    prompt_count = 0;
    push_str("12 3>");
    wait_drain("l6");
    chk("l6_count", {27'd0, byte_count}, 0);
    chk("l6_prompt", prompt_count, 1);
    chk("l6_flags", {29'd0, e_char, e_nibble, e_ovf}, 0);

    // Reset mid-stream.
    push_str("41 0");
    wait_drain("l7a");
    chk("l7_partial", {27'd0, byte_count}, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("l7_rst_count", {27'd0, byte_count}, 0);
    reset = 1'b0;
    @(negedge clk);
    push_str("0D\r");
    wait_ready("l7");
    chk("l7_count", {27'd0, byte_count}, 1);
    chk_byte("l7_b0", 0, 8'h0D);
    chk("l7_flags", {29'd0, e_char, e_nibble, e_ovf}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
